// File: rtl/alu_ctrl_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_ctrl_seq
// Purpose  : Registered RISC-V ALU-control decoder with a valid/ready output
//            register. Define ALU_CTRL_MUL_EN to add MUL decode and MUL_WAIT.
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq #(
  parameter int MUL_LATENCY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] aluoperation,
  output logic       alusrc_imm,
  output logic       illegal,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
`ifdef ALU_CTRL_MUL_EN
  localparam logic [1:0] ST_MUL_WAIT = 2'd2;
  localparam logic [3:0] OP_MUL      = 4'b1010;
  localparam logic [3:0] CNT_INIT    = 4'(MUL_LATENCY - 1);
`endif

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SLLI = 4'b0101;
  localparam logic [3:0] OP_SRLI = 4'b0110;
  localparam logic [3:0] OP_SLLR = 4'b0111;
  localparam logic [3:0] OP_SRLR = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_ILL  = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef ALU_CTRL_MUL_EN
  localparam logic [6:0] F7_MUL  = 7'b0000001;
`endif

  if ((MUL_LATENCY < 1) || (MUL_LATENCY > 15)) begin : g_bad_mul_latency
    $error("alu_ctrl_seq: MUL_LATENCY must be in 1..15");
  end

  logic [1:0] state_q, state_d;
  logic [3:0] aluoperation_q, aluoperation_d;
  logic       alusrc_imm_q, alusrc_imm_d;
  logic       illegal_q, illegal_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic       accept;
  logic [3:0] dec_op;
  logic       dec_imm_raw;
  logic       dec_imm;
  logic       dec_ill;
  logic       f7_base;
  logic       dec_wait;

  assign f7_base = (funct7 == F7_BASE);

  // Combinational decode of the raw instruction fields
  always_comb begin
    dec_op      = OP_ILL;
    dec_imm_raw = 1'b0;
    case (opcode)
      OPC_OP: begin
        case (funct3)
          3'b000: begin
            if (f7_base)                dec_op = OP_ADD;
            else if (funct7 == F7_ALT)  dec_op = OP_SUB;
`ifdef ALU_CTRL_MUL_EN
            else if (funct7 == F7_MUL)  dec_op = OP_MUL;
`endif
          end
          3'b100:  if (f7_base) dec_op = OP_XOR;
          3'b110:  if (f7_base) dec_op = OP_OR;
          3'b111:  if (f7_base) dec_op = OP_AND;
          3'b010:  if (f7_base) dec_op = OP_SLT;
          3'b001:  if (f7_base) dec_op = OP_SLLR;
          3'b101:  if (f7_base) dec_op = OP_SRLR;
          default: dec_op = OP_ILL;
        endcase
      end
      OPC_OPIMM: begin
        dec_imm_raw = 1'b1;
        case (funct3)
          3'b000:  dec_op = OP_ADD;
          3'b100:  dec_op = OP_XOR;
          3'b110:  dec_op = OP_OR;
          3'b111:  dec_op = OP_AND;
          3'b010:  dec_op = OP_SLT;
          3'b001:  if (f7_base) dec_op = OP_SLLI;
          3'b101:  if (f7_base) dec_op = OP_SRLI;
          default: dec_op = OP_ILL;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_LUI: begin
        dec_op      = OP_ADD;
        dec_imm_raw = 1'b1;
      end
      OPC_BRANCH: dec_op = OP_SUB;
      default:    dec_op = OP_ILL;
    endcase
  end

  // Illegal encodings never select the immediate operand
  assign dec_ill = (dec_op == OP_ILL);
  assign dec_imm = dec_imm_raw & ~dec_ill;

`ifdef ALU_CTRL_MUL_EN
  assign dec_wait = (dec_op == OP_MUL) && (MUL_LATENCY > 1);
`else
  assign dec_wait = 1'b0;
`endif

  assign in_ready = ~reset & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready));
  assign accept   = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      aluoperation_q <= 4'b0000;
      alusrc_imm_q   <= 1'b0;
      illegal_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      aluoperation_q <= aluoperation_d;
      alusrc_imm_q   <= alusrc_imm_d;
      illegal_q      <= illegal_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= busy_d;
    end
  end

`ifdef ALU_CTRL_MUL_EN
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_MUL_WAIT) cnt_d = cnt_q - 4'd1;
    if (accept && dec_wait)     cnt_d = CNT_INIT;
  end
`endif

  // Next-state logic; an accept is only possible from IDLE or draining HOLD
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: if (out_ready) state_d = ST_IDLE;
`ifdef ALU_CTRL_MUL_EN
      ST_MUL_WAIT: if (cnt_q == 4'd1) state_d = ST_HOLD;
`endif
      default: state_d = state_q;
    endcase
    if (accept) begin
`ifdef ALU_CTRL_MUL_EN
      state_d = dec_wait ? ST_MUL_WAIT : ST_HOLD;
`else
      state_d = ST_HOLD;
`endif
    end
  end

  // Registered outputs follow the next state and the accepted decode
  always_comb begin
    out_valid_d    = (state_d == ST_HOLD);
`ifdef ALU_CTRL_MUL_EN
    busy_d         = (state_d == ST_MUL_WAIT);
`else
    busy_d         = 1'b0;
`endif
    aluoperation_d = accept ? dec_op  : aluoperation_q;
    alusrc_imm_d   = accept ? dec_imm : alusrc_imm_q;
    illegal_d      = accept ? dec_ill : illegal_q;
  end

  assign out_valid    = out_valid_q;
  assign aluoperation = aluoperation_q;
  assign alusrc_imm   = alusrc_imm_q;
  assign illegal      = illegal_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_ctrl_seq
// Purpose  : Self-checking bench for alu_ctrl_seq (vector table, directed
//            corner sequences, randomized traffic against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_seq;

  localparam int LAT = 3;
`ifdef ALU_CTRL_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  // Per-funct3 codes (nibble index = funct3); 4'hF marks an unused funct3
  localparam logic [31:0] R_TAB = {4'h4, 4'h3, 4'h8, 4'h2, 4'hF, 4'h9, 4'h7, 4'h0};
  localparam logic [31:0] I_TAB = {4'h4, 4'h3, 4'h6, 4'h2, 4'hF, 4'h9, 4'h5, 4'h0};

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] aluoperation;
  logic       alusrc_imm;
  logic       illegal;
  logic       busy;

  alu_ctrl_seq #(.MUL_LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .aluoperation (aluoperation),
    .alusrc_imm   (alusrc_imm),
    .illegal      (illegal),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       ill;
    logic       imm;
    logic [3:0] op;
  } dec_t;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] op;
    logic       imm;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic ordy);
    in_valid  = v;
    opcode    = opc;
    funct3    = f3;
    funct7    = f7;
    out_ready = ordy;
  endtask

  task automatic add_vec(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [3:0] op, input logic imm, input logic ill);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.op = op; v.imm = imm; v.ill = ill;
    vecs.push_back(v);
  endtask

  // Reference decode straight from the instruction-set rules
  function automatic dec_t ref_dec(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    dec_t d;
    d.op  = 4'hF;
    d.imm = 1'b0;
    if (opc == 7'b0110011) begin
      if (f7 == 7'h00)                          d.op = R_TAB[f3*4 +: 4];
      else if (f3 == 3'd0 && f7 == 7'h20)       d.op = 4'h1;
      else if (f3 == 3'd0 && f7 == 7'h01 && MUL_EN) d.op = 4'hA;
    end else if (opc == 7'b0010011) begin
      d.imm = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) d.op = (f7 == 7'h00) ? I_TAB[f3*4 +: 4] : 4'hF;
      else                          d.op = I_TAB[f3*4 +: 4];
    end else if (opc == 7'b0000011 || opc == 7'b0100011 || opc == 7'b1100111 || opc == 7'b0110111) begin
      d.op  = 4'h0;
      d.imm = 1'b1;
    end else if (opc == 7'b1100011) begin
      d.op = 4'h1;
    end
    d.ill = (d.op == 4'hF);
    if (d.ill) d.imm = 1'b0;
    return d;
  endfunction

  // Reference model state: pending item and cycles left before it is presented
  logic       m_have;
  int         m_wait;
  dec_t       m_out;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 7'd0, 3'd0, 7'd0, 1'b1);

    // Table: sub first, then an addi/xori/slli stream, then the rest
    add_vec(7'b0110011, 3'b000, 7'h20, 4'h1, 1'b0, 1'b0);
    add_vec(7'b0010011, 3'b000, 7'h3A, 4'h0, 1'b1, 1'b0);
    add_vec(7'b0010011, 3'b100, 7'h55, 4'h2, 1'b1, 1'b0);
    add_vec(7'b0010011, 3'b001, 7'h00, 4'h5, 1'b1, 1'b0);
    add_vec(7'b0010011, 3'b101, 7'h00, 4'h6, 1'b1, 1'b0);
    add_vec(7'b0010011, 3'b101, 7'h20, 4'hF, 1'b0, 1'b1);
    add_vec(7'b0010011, 3'b001, 7'h20, 4'hF, 1'b0, 1'b1);
    add_vec(7'b0010011, 3'b011, 7'h00, 4'hF, 1'b0, 1'b1);
    add_vec(7'b0010011, 3'b010, 7'h00, 4'h9, 1'b1, 1'b0);
    add_vec(7'b0110011, 3'b000, 7'h00, 4'h0, 1'b0, 1'b0);
    add_vec(7'b0110011, 3'b100, 7'h00, 4'h2, 1'b0, 1'b0);
    add_vec(7'b0110011, 3'b110, 7'h00, 4'h3, 1'b0, 1'b0);
    add_vec(7'b0110011, 3'b111, 7'h00, 4'h4, 1'b0, 1'b0);
    add_vec(7'b0110011, 3'b010, 7'h00, 4'h9, 1'b0, 1'b0);
    add_vec(7'b0110011, 3'b001, 7'h00, 4'h7, 1'b0, 1'b0);
    add_vec(7'b0110011, 3'b101, 7'h00, 4'h8, 1'b0, 1'b0);
    add_vec(7'b0110011, 3'b101, 7'h20, 4'hF, 1'b0, 1'b1);
    add_vec(7'b0110011, 3'b100, 7'h20, 4'hF, 1'b0, 1'b1);
    add_vec(7'b0110011, 3'b011, 7'h00, 4'hF, 1'b0, 1'b1);
    add_vec(7'b0000011, 3'b010, 7'h11, 4'h0, 1'b1, 1'b0);
    add_vec(7'b0100011, 3'b010, 7'h00, 4'h0, 1'b1, 1'b0);
    add_vec(7'b1100111, 3'b000, 7'h00, 4'h0, 1'b1, 1'b0);
    add_vec(7'b0110111, 3'b101, 7'h7F, 4'h0, 1'b1, 1'b0);
    add_vec(7'b1100011, 3'b001, 7'h00, 4'h1, 1'b0, 1'b0);
    add_vec(7'b1111111, 3'b000, 7'h00, 4'hF, 1'b0, 1'b1);
    add_vec(7'b0010111, 3'b000, 7'h00, 4'hF, 1'b0, 1'b1);

    // Reset values
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_aluop", aluoperation, 4'h0);
    chk("rst_imm", alusrc_imm, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);
    tick();
    chk("idle_out_valid", out_valid, 1'b0);

    // Back-to-back vectors with out_ready held high: no bubbles
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].opc, vecs[i].f3, vecs[i].f7, 1'b1);
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_aluop", i), aluoperation, vecs[i].op);
      chk($sformatf("vec%0d_imm", i), alusrc_imm, vecs[i].imm);
      chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill);
      chk($sformatf("vec%0d_busy", i), busy, 1'b0);
    end
    drive(1'b0, 7'd0, 3'd0, 7'd0, 1'b1);
    tick();
    chk("drain_out_valid", out_valid, 1'b0);

    // MUL latency / illegal without MUL support
    drive(1'b1, 7'b0110011, 3'b000, 7'h01, 1'b1);
    tick();
    drive(1'b0, 7'd0, 3'd0, 7'd0, 1'b1);
`ifdef ALU_CTRL_MUL_EN
    for (int k = 0; k < LAT - 1; k++) begin
      #1;
      chk($sformatf("mul_wait%0d_in_ready", k), in_ready, 1'b0);
      chk($sformatf("mul_wait%0d_busy", k), busy, 1'b1);
      chk($sformatf("mul_wait%0d_out_valid", k), out_valid, 1'b0);
      tick();
    end
    chk("mul_out_valid", out_valid, 1'b1);
    chk("mul_aluop", aluoperation, 4'hA);
    chk("mul_illegal", illegal, 1'b0);
    chk("mul_busy", busy, 1'b0);
`else
    chk("nomul_out_valid", out_valid, 1'b1);
    chk("nomul_aluop", aluoperation, 4'hF);
    chk("nomul_illegal", illegal, 1'b1);
    chk("nomul_busy", busy, 1'b0);
`endif
    tick();
    chk("mul_drain_out_valid", out_valid, 1'b0);

    // Backpressure: an AND held for 4 cycles, competing input ignored
    drive(1'b1, 7'b0110011, 3'b111, 7'h00, 1'b0);
    tick();
    drive(1'b1, 7'b0110011, 3'b100, 7'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", k), in_ready, 1'b0);
      chk($sformatf("bp%0d_out_valid", k), out_valid, 1'b1);
      chk($sformatf("bp%0d_aluop", k), aluoperation, 4'h4);
      tick();
    end
    drive(1'b0, 7'd0, 3'd0, 7'd0, 1'b1);
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    tick();
    chk("bp_release_out_valid", out_valid, 1'b0);
    chk("bp_release_aluop", aluoperation, 4'h4);

    // Reset while a MUL is pending (MUL_WAIT, or HOLD without MUL support)
    drive(1'b1, 7'b0110011, 3'b000, 7'h01, 1'b0);
    tick();
    drive(1'b0, 7'd0, 3'd0, 7'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1'b0);
    tick();
    reset = 1'b0;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_aluop", aluoperation, 4'h0);
    chk("abort_illegal", illegal, 1'b0);
    for (int k = 0; k < LAT + 1; k++) begin
      #1;
      chk($sformatf("abort%0d_in_ready", k), in_ready, 1'b1);
      tick();
      chk($sformatf("abort%0d_out_valid", k), out_valid, 1'b0);
    end

    // Randomized traffic against the reference model
    m_have = 1'b0;
    m_wait = 0;
    m_out  = '0;
    for (int n = 0; n < 400; n++) begin
      logic [6:0] opc;
      logic [6:0] f7;
      logic       v;
      logic       ordy;
      logic       exp_rdy;
      dec_t       d;
      case ($urandom_range(0, 9))
        0, 1, 2: opc = 7'b0110011;
        3, 4:    opc = 7'b0010011;
        5:       opc = 7'b0000011;
        6:       opc = 7'b0100011;
        7:       opc = 7'b1100011;
        8:       opc = 7'b1100111;
        default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      drive(v, opc, 3'($urandom), f7, ordy);
      exp_rdy = !m_have || (m_wait == 0 && ordy);
      #1;
      chk($sformatf("rnd%0d_in_ready", n), in_ready, exp_rdy);
      @(posedge clk);
      if (v && exp_rdy) begin
        d      = ref_dec(opc, funct3, f7);
        m_have = 1'b1;
        m_out  = d;
        m_wait = (d.op == 4'hA) ? LAT - 1 : 0;
      end else if (m_have && m_wait == 0 && ordy) begin
        m_have = 1'b0;
      end else if (m_have && m_wait > 0) begin
        m_wait = m_wait - 1;
      end
      #1;
      chk($sformatf("rnd%0d_out_valid", n), out_valid, m_have && m_wait == 0);
      chk($sformatf("rnd%0d_busy", n), busy, m_have && m_wait > 0);
      chk($sformatf("rnd%0d_aluop", n), aluoperation, m_out.op);
      chk($sformatf("rnd%0d_imm", n), alusrc_imm, m_out.imm);
      chk($sformatf("rnd%0d_illegal", n), illegal, m_out.ill);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered ALU-control decoder for the RISC-V core: it converts instruction fields (opcode, funct3, funct7) into the 4-bit `aluoperation` code consumed by `alu`, plus operand-select and illegal-instruction flags. Decoded results leave through a one-entry output register with a valid/ready handshake. When MUL is compiled in, a MUL is held for a configurable number of cycles so a multi-cycle multiplier can settle before the code is released downstream.

## Interface
- `MUL_LATENCY`, default 3. Cycles from MUL acceptance to `out_valid`; legal range 1..15.
- `clk` in 1. Single clock; all state updates on the rising edge.
- `reset` in 1. Synchronous, active-high.
- `in_valid` in 1. Instruction fields are valid.
- `in_ready` out 1. Block can accept this cycle.
- `opcode` in 7. instr[6:0].
- `funct3` in 3. instr[14:12].
- `funct7` in 7. instr[31:25].
- `out_valid` out 1. Decoded code is held and valid.
- `out_ready` in 1. Downstream consumes this cycle.
- `aluoperation` out 4. Code for `alu`.
- `alusrc_imm` out 1. 1 = operand B is the immediate.
- `illegal` out 1. Unsupported encoding; `aluoperation` = 1111.
- `busy` out 1. High while in MUL_WAIT.

## Operation
- ALU codes:
  - add 0000, sub 0001, xor 0010, or 0011, and 0100.
  - shift-immediate: sll-imm 0101, srl-imm 0110.
  - shift-register: sll-reg 0111, srl-reg 1000.
  - slt 1001, mul 1010, illegal/default 1111.
- R-type, opcode 0110011, `alusrc_imm` = 0:
  - f3 000 with f7 0000000 → add; f7 0100000 → sub; f7 0000001 → mul.
  - f3 100 → xor; 110 → or; 111 → and; 010 → slt. These require f7 0000000.
  - f3 001 → sll-reg; 101 → srl-reg. These require f7 0000000.
  - Any other f3/f7 combination → illegal.
- I-type ALU, opcode 0010011, `alusrc_imm` = 1:
  - f3 000 → add; 100 → xor; 110 → or; 111 → and; 010 → slt.
  - f3 001 → sll-imm and f3 101 → srl-imm. Both require f7 0000000; otherwise illegal.
  - Any other f3 → illegal.
- Other opcodes:
  - Load 0000011, store 0100011, jalr 1100111, lui 0110111 → add, `alusrc_imm` = 1.
  - Branch 1100011 → sub, `alusrc_imm` = 0.
  - All other opcodes → illegal: `illegal` = 1, `aluoperation` = 1111, `alusrc_imm` = 0.
- FSM states: IDLE, HOLD, MUL_WAIT.
  - IDLE: `in_ready` = 1. On accept, a non-MUL goes to HOLD. A MUL goes to HOLD if `MUL_LATENCY` = 1, otherwise to MUL_WAIT with cnt = `MUL_LATENCY`−1.
  - MUL_WAIT: `in_ready` = 0, `busy` = 1. cnt decrements each cycle. When cnt reaches 1, go to HOLD next edge. `out_valid` first rises `MUL_LATENCY` cycles after the accept edge.
  - HOLD: `out_valid` = 1 and the outputs are stable. `in_ready` = `out_ready`.
    - `out_ready` high with a new accept in the same cycle: load the new decode (HOLD or MUL_WAIT per the rules above).
    - `out_ready` high with no accept: return to IDLE.
    - `out_ready` low: stay in HOLD, outputs unchanged.
- Accept = `in_valid` & `in_ready`. Inputs are ignored when not accepted.

## Timing
- Reset (sync, while `reset` = 1):
  - state = IDLE, cnt = 0.
  - `out_valid` = 0, `aluoperation` = 0000, `alusrc_imm` = 0, `illegal` = 0, `busy` = 0.
  - `in_ready` is forced to 0 while `reset` is high.
- Reset mid-MUL_WAIT or mid-HOLD aborts: the pending code is discarded with no `out_valid` pulse.
- Latency:
  - Non-MUL: `out_valid` 1 cycle after the accept edge.
  - MUL: `MUL_LATENCY` cycles after the accept edge.
- Throughput: one non-MUL per cycle when `out_ready` is held high. Back-to-back accepts use HOLD pass-through.
- Outputs are registered; only `in_ready` is combinational (from state and `out_ready`).
- `out_valid` never drops without `out_ready` having been high on the prior edge.

## Configuration
- `ALU_CTRL_MUL_EN` defined:
  - f7 0000001 / f3 000 R-type decodes to 1010.
  - MUL_WAIT, the counter and the `MUL_LATENCY` behaviour are present.
- `ALU_CTRL_MUL_EN` not defined:
  - That encoding decodes as illegal (1111, `illegal` = 1).
  - No MUL_WAIT state and no counter; `busy` is tied to 0.
  - `MUL_LATENCY` is ignored.

## Test plan
- Reset, then hold `in_valid` = 0: all outputs at their reset values, `in_ready` = 1 after reset deasserts.
- opcode 0110011, f3 000, f7 0100000, `out_ready` = 1:
  - Next cycle `out_valid` = 1, `aluoperation` = 0001, `alusrc_imm` = 0.
- Stream of addi, xori, slli (f7 0) with `out_ready` = 1:
  - Outputs 0000, 0010, 0101 on consecutive cycles, `alusrc_imm` = 1, no bubbles.
- MUL with `MUL_LATENCY` = 3 and MUL compiled in:
  - `busy` = 1 for 2 cycles, `in_ready` = 0 during that time.
  - `out_valid` rises 3 cycles after accept with 1010.
- Same MUL without `ALU_CTRL_MUL_EN`: 1 cycle later `illegal` = 1, `aluoperation` = 1111. Also check opcode 1111111 gives the same.
- Backpressure: hold `out_ready` = 0 for 4 cycles after an and-accept.
  - `out_valid` = 1 and `aluoperation` = 0100 stay stable, `in_ready` = 0.
- Reset asserted in MUL_WAIT: next cycle IDLE with `out_valid` = 0.
